// File: rtl/rtc_bus_ctrl.sv
// Multiplexed-bus master for an RTC: an address phase then a data phase, each made
// of a strobe-active window and a recovery window; every output comes from a flop.
module rtc_bus_ctrl #(
    parameter int T_ACT = 4,
    parameter int T_REC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_wr,
    input  logic       start_rd,
    input  logic [7:0] dir_in,
    input  logic [7:0] dato_in,
    input  logic [7:0] ad_in,
    output logic [7:0] direccion,
    output logic [7:0] dato,
    output logic       seleccion,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_rd,
    output logic       ocupado,
    output logic       listo
);

    localparam logic [7:0] ACT_LOAD = 8'(T_ACT - 1);
    localparam logic [7:0] REC_LOAD = 8'(T_REC - 1);

    typedef enum logic [2:0] {
        IDLE, DIR_ACT, DIR_REC, DATO_ACT, DATO_REC, FIN
    } state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       op_wr, op_wr_nx;
    logic       accept;
    logic       capture;

    logic cs_n_d, ad_n_d, wr_n_d, rd_n_d, sel_d, oe_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            op_wr <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_wr <= op_wr_nx;
        end
    end

    // The counter is loaded with (length - 1) on every state entry and counts down to zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_wr_nx = op_wr;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start_wr || start_rd) begin
                    accept   = 1'b1;
                    op_wr_nx = start_wr;
                    state_nx = DIR_ACT;
                    cnt_nx   = ACT_LOAD;
                end
            end
            DIR_ACT: begin
                if (cnt == 8'd0) begin
                    state_nx = DIR_REC;
                    cnt_nx   = REC_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            DIR_REC: begin
                if (cnt == 8'd0) begin
                    state_nx = DATO_ACT;
                    cnt_nx   = ACT_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            DATO_ACT: begin
                if (cnt == 8'd0) begin
                    state_nx = DATO_REC;
                    cnt_nx   = REC_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            DATO_REC: begin
                if (cnt == 8'd0) begin
                    state_nx = FIN;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            FIN: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Bus pins are decoded from the upcoming state so they change together with it.
    always_comb begin
        cs_n_d = 1'b1;
        ad_n_d = 1'b1;
        wr_n_d = 1'b1;
        rd_n_d = 1'b1;
        sel_d  = 1'b0;
        oe_d   = 1'b0;
        case (state_nx)
            DIR_ACT: begin
                cs_n_d = 1'b0;
                ad_n_d = 1'b0;
                wr_n_d = 1'b0;
                oe_d   = 1'b1;
            end
            DIR_REC:  oe_d = 1'b1;
            DATO_ACT: begin
                cs_n_d = 1'b0;
                sel_d  = 1'b1;
                wr_n_d = !op_wr_nx;
                rd_n_d = op_wr_nx;
                oe_d   = op_wr_nx;
            end
            DATO_REC: begin
                sel_d = 1'b1;
                oe_d  = op_wr_nx;
            end
            default: ;
        endcase
    end

    assign capture = (state == DATO_ACT) && (cnt == 8'd0) && !op_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n      <= 1'b1;
            ad_n      <= 1'b1;
            wr_n      <= 1'b1;
            rd_n      <= 1'b1;
            seleccion <= 1'b0;
            bus_oe    <= 1'b0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            direccion <= 8'h00;
            dato      <= 8'h00;
            dato_rd   <= 8'h00;
        end else begin
            cs_n      <= cs_n_d;
            ad_n      <= ad_n_d;
            wr_n      <= wr_n_d;
            rd_n      <= rd_n_d;
            seleccion <= sel_d;
            bus_oe    <= oe_d;
            ocupado   <= (state_nx != IDLE);
            listo     <= (state_nx == FIN);
            if (accept) begin
                direccion <= dir_in;
                if (start_wr) dato <= dato_in;
            end
            if (capture) dato_rd <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: a timeline model (cycle position inside a transfer) checks the
// default instance every cycle; a second instance runs with one-cycle phases.
module tb_rtc_bus_ctrl;

    localparam int TA = 4;
    localparam int TR = 2;
    localparam int L  = 1 + 2 * (TA + TR);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_wr = 1'b0;
    logic       start_rd = 1'b0;
    logic [7:0] dir_in = 8'h00;
    logic [7:0] dato_in = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] direccion, dato, dato_rd;
    logic       seleccion, bus_oe, cs_n, ad_n, wr_n, rd_n, ocupado, listo;

    logic       s_wr = 1'b0;
    logic       s_rd = 1'b0;
    logic [7:0] s_dir_in = 8'h5C;
    logic [7:0] s_dato_in = 8'h3E;
    logic [7:0] s_direccion, s_dato, s_dato_rd;
    logic       s_sel, s_oe, s_cs_n, s_ad_n, s_wr_n, s_rd_n, s_ocupado, s_listo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtc_bus_ctrl #(.T_ACT(TA), .T_REC(TR)) dut (
        .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
        .dir_in(dir_in), .dato_in(dato_in), .ad_in(ad_in),
        .direccion(direccion), .dato(dato), .seleccion(seleccion), .bus_oe(bus_oe),
        .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
        .dato_rd(dato_rd), .ocupado(ocupado), .listo(listo)
    );

    rtc_bus_ctrl #(.T_ACT(1), .T_REC(1)) u_small (
        .clk(clk), .reset(reset), .start_wr(s_wr), .start_rd(s_rd),
        .dir_in(s_dir_in), .dato_in(s_dato_in), .ad_in(ad_in),
        .direccion(s_direccion), .dato(s_dato), .seleccion(s_sel), .bus_oe(s_oe),
        .cs_n(s_cs_n), .ad_n(s_ad_n), .wr_n(s_wr_n), .rd_n(s_rd_n),
        .dato_rd(s_dato_rd), .ocupado(s_ocupado), .listo(s_listo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position inside the transfer (1 = first address-strobe cycle, L = FIN).
    bit         m_busy = 0;
    int         m_pos = 0;
    bit         m_wr = 0;
    logic [7:0] m_dir = 8'h00, m_dato = 8'h00, m_rd = 8'h00;

    initial begin : model_and_compare
        logic [3:0] e_strb;
        logic       e_sel, e_oe, e_listo;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 0; m_pos = 0; m_wr = 0;
                m_dir = 8'h00; m_dato = 8'h00; m_rd = 8'h00;
            end else if (m_busy) begin
                if (!m_wr && m_pos == 2 * TA + TR) m_rd = ad_in;
                if (m_pos == L) m_busy = 0;
                else m_pos++;
            end else if (start_wr || start_rd) begin
                m_busy = 1; m_pos = 1; m_wr = start_wr;
                m_dir = dir_in;
                if (start_wr) m_dato = dato_in;
            end
            #1;
            e_strb = 4'b1111; e_sel = 1'b0; e_oe = 1'b0; e_listo = 1'b0;
            if (m_busy) begin
                if (m_pos <= TA) begin
                    e_strb = 4'b0001; e_oe = 1'b1;
                end else if (m_pos <= TA + TR) begin
                    e_oe = 1'b1;
                end else if (m_pos <= 2 * TA + TR) begin
                    e_strb = {1'b0, 1'b1, !m_wr, m_wr}; e_sel = 1'b1; e_oe = m_wr;
                end else if (m_pos <= 2 * (TA + TR)) begin
                    e_sel = 1'b1; e_oe = m_wr;
                end else begin
                    e_listo = 1'b1;
                end
            end
            chk("strobes", {cs_n, ad_n, wr_n, rd_n}, e_strb);
            chk("seleccion", seleccion, e_sel);
            chk("bus_oe", bus_oe, e_oe);
            chk("ocupado", ocupado, m_busy);
            chk("listo", listo, e_listo);
            chk("direccion", direccion, m_dir);
            chk("dato", dato, m_dato);
            chk("dato_rd", dato_rd, m_rd);
        end
    end

    // Issues a request at the current time and observes a fixed 60-cycle window.
    task automatic run(input logic wr, input logic rd, input logic [7:0] dir, input logic [7:0] dat,
                       input int hold, input int inj, input int n_want,
                       output int lat, output int rdl, output int wrl, output int nl);
        start_wr = wr; start_rd = rd; dir_in = dir; dato_in = dat;
        @(posedge clk); #1;
        lat = 0; rdl = 0; wrl = 0; nl = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == hold) begin start_wr = 1'b0; start_rd = 1'b0; end
            if (c == inj) begin start_rd = 1'b1; dir_in = 8'hAA; end
            if (c == inj + 1) start_rd = 1'b0;
            if (!rd_n) rdl++;
            if (!wr_n) wrl++;
            if (listo) begin
                nl++;
                if (nl == n_want) lat = c;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [6:0] small_exp [6];

    initial begin : stimulus
        int lat, rdl, wrl, nl;
        small_exp[0] = 7'b0001010;
        small_exp[1] = 7'b1111010;
        small_exp[2] = 7'b0101110;
        small_exp[3] = 7'b1111110;
        small_exp[4] = 7'b1111001;
        small_exp[5] = 7'b1111000;

        repeat (3) @(negedge clk);
        chk("rst_direccion", direccion, 8'h00);
        chk("rst_dato_rd", dato_rd, 8'h00);
        chk("rst_strobes", {cs_n, ad_n, wr_n, rd_n, bus_oe}, 5'b11110);

        // Release reset with a write already waiting: accepted on the first edge.
        reset = 1'b1;
        run(1'b1, 1'b0, 8'h21, 8'h59, 1, 0, 1, lat, rdl, wrl, nl);
        chk("wr_latency", lat, 13);
        chk("wr_wr_low", wrl, 8);
        chk("wr_rd_low", rdl, 0);
        chk("wr_dato_rd", dato_rd, 8'h00);
        chk("wr_dato", dato, 8'h59);

        ad_in = 8'h45;
        run(1'b0, 1'b1, 8'h22, 8'h00, 1, 0, 1, lat, rdl, wrl, nl);
        chk("rd_latency", lat, 13);
        chk("rd_rd_low", rdl, 4);
        chk("rd_wr_low", wrl, 4);
        chk("rd_dato_rd", dato_rd, 8'h45);
        chk("rd_direccion", direccion, 8'h22);

        run(1'b1, 1'b1, 8'h5A, 8'hC3, 1, 0, 1, lat, rdl, wrl, nl);
        chk("both_rd_low", rdl, 0);
        chk("both_wr_low", wrl, 8);
        chk("both_dato", dato, 8'hC3);

        run(1'b1, 1'b0, 8'h33, 8'h77, 1, 7, 1, lat, rdl, wrl, nl);
        chk("inj_listo_count", nl, 1);
        chk("inj_direccion", direccion, 8'h33);
        chk("inj_rd_low", rdl, 0);

        // Request held high: second transfer starts after one IDLE cycle.
        run(1'b1, 1'b0, 8'h44, 8'h88, 20, 0, 2, lat, rdl, wrl, nl);
        chk("b2b_listo_count", nl, 2);
        chk("b2b_second_listo", lat, 27);

        // Reset in the middle of a write's data strobe.
        start_wr = 1'b1; dir_in = 8'h66; dato_in = 8'h99;
        @(posedge clk); #1;
        start_wr = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("pre_abort_wr_n", wr_n, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("abort_strobes", {cs_n, ad_n, wr_n, rd_n}, 4'b1111);
        chk("abort_oe_listo_busy", {bus_oe, listo, ocupado}, 3'b000);
        chk("abort_dato_rd", dato_rd, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run(1'b1, 1'b0, 8'h10, 8'h20, 1, 0, 1, lat, rdl, wrl, nl);
        chk("post_abort_latency", lat, 13);
        chk("post_abort_listo_count", nl, 1);
        chk("post_abort_direccion", direccion, 8'h10);

        // One-cycle phases on the small instance.
        s_wr = 1'b1;
        @(posedge clk); #1;
        s_wr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("small_cycle%0d", c + 1),
                {s_cs_n, s_ad_n, s_wr_n, s_rd_n, s_sel, s_oe, s_listo}, small_exp[c]);
            @(posedge clk); #1;
        end
        chk("small_direccion", s_direccion, 8'h5C);
        chk("small_dato", s_dato, 8'h3E);
        chk("small_idle", {s_ocupado, s_dato_rd}, 9'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_ctrl.md
RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter T_ACT, default 4: strobe-active cycles per bus phase (legal range 1..255).
REQ-002 Parameter T_REC, default 2: recovery cycles after each strobe (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start_wr  input  1  request a write cycle; sampled in IDLE only.
REQ-006 start_rd  input  1  request a read cycle; sampled in IDLE only.
REQ-007 dir_in  input  8  RTC register address for the requested cycle.
REQ-008 dato_in  input  8  write data for the requested cycle.
REQ-009 ad_in  input  8  value read back from the external AD bus.
REQ-010 direccion  output  8  latched address; drives the address input of the downstream output mux.
REQ-011 dato  output  8  latched write data; drives the data input of the downstream output mux.
REQ-012 seleccion  output  1  mux select: 0 = address phase, 1 = data phase.
REQ-013 bus_oe  output  1  tristate enable for the AD pins: 1 = FPGA drives the bus.
REQ-014 cs_n, ad_n, wr_n, rd_n  output  1 each  active-low RTC bus strobes.
REQ-015 dato_rd  output  8  data captured by the most recent read cycle.
REQ-016 ocupado  output  1  high from the cycle after acceptance until the FIN cycle, inclusive.
REQ-017 listo  output  1  single-cycle completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, DIR_ACT, DIR_REC, DATO_ACT, DATO_REC and FIN.
REQ-019 All outputs SHALL be driven from registers, with no combinational path from any input to any strobe.
REQ-020 In IDLE, if start_wr=1, the block SHALL latch dir_in into direccion and dato_in into dato, record op=write and move to DIR_ACT.
REQ-021 In IDLE, if only start_rd=1, the block SHALL latch dir_in, record op=read and move to DIR_ACT.
REQ-022 If start_wr and start_rd are both 1, write SHALL win and the read request SHALL be dropped.
REQ-023 Requests outside IDLE SHALL be ignored, and direccion and dato SHALL remain stable for the whole cycle.
REQ-024 DIR_ACT SHALL last T_ACT cycles with cs_n=0, ad_n=0, wr_n=0, rd_n=1, seleccion=0, bus_oe=1.
REQ-025 DIR_REC SHALL last T_REC cycles with cs_n=1, ad_n=1, wr_n=1, rd_n=1, seleccion=0, bus_oe=1 (address hold).
REQ-026 DATO_ACT SHALL last T_ACT cycles with cs_n=0, ad_n=1 and seleccion=1.
REQ-027 In DATO_ACT for a write: wr_n=0, rd_n=1, bus_oe=1.
REQ-028 In DATO_ACT for a read: wr_n=1, rd_n=0, bus_oe=0.
REQ-029 For a read, dato_rd SHALL load ad_in on the clock edge that ends the last DATO_ACT cycle; dato_rd SHALL otherwise hold.
REQ-030 DATO_REC SHALL last T_REC cycles with all strobes at 1.
REQ-031 In DATO_REC, seleccion=1 and bus_oe=1 for a write (data hold); bus_oe=0 for a read.
REQ-032 FIN SHALL last 1 cycle with listo=1 and strobes high, then return to IDLE.
REQ-033 If acceptance occurs on edge k, listo SHALL be high in cycle k+1+2*(T_ACT+T_REC); with the defaults this is k+13.
REQ-034 A new request present during FIN SHALL NOT be accepted until IDLE; back-to-back cycles are therefore separated by at least one IDLE cycle.
REQ-035 The phase counter SHALL be 8 bits, reload on every state entry and never wrap within a phase.

Reset
REQ-036 While reset=0, the block SHALL be in IDLE, regardless of clk.
REQ-037 While reset=0: cs_n=ad_n=wr_n=rd_n=1, seleccion=0, bus_oe=0, ocupado=0, listo=0, direccion=dato=dato_rd=8'h00, counter=0.
REQ-038 Reset asserted mid-cycle SHALL abort the transfer immediately, with strobes released asynchronously and no listo pulse.
REQ-039 After reset is released, the first request SHALL be accepted on the first rising edge.

Verification
REQ-040 Write: dir_in=8'h21, dato_in=8'h59, start_wr pulse -> DIR_ACT 4 cycles with bus=8'h21, 2 recovery cycles, DATO_ACT 4 cycles with wr_n=0 and seleccion=1, listo at k+13, dato_rd unchanged.
REQ-041 Read: dir_in=8'h22, ad_in=8'h45 held, start_rd pulse -> rd_n low 4 cycles with bus_oe=0, dato_rd=8'h45 after the capture edge, listo at k+13.
REQ-042 Simultaneous start_wr=start_rd=1 -> write cycle executes, rd_n never asserted.
REQ-043 start_rd pulsed during a write's DATO_ACT -> ignored; exactly one listo and direccion unchanged.
REQ-044 reset=0 during DATO_ACT of a write -> all strobes 1 and bus_oe=0 within the same cycle, no listo; a following write completes normally.
REQ-045 T_ACT=1, T_REC=1 -> listo at k+5, each phase exactly one cycle.
